// File: rtl/alu_step_sequencer_pkg.sv
// Shared types and constants for the register-register ALU step sequencer.
// Op codes match the DataPath ALU decode.
package alu_seq_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_ADD = 5'b00011;
  localparam logic [OPW-1:0] OP_AND = 5'b00101;
  localparam logic [OPW-1:0] OP_MUL = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV = 5'b01111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADY = 3'd1,
    EXEC  = 3'd2,
    WRZ   = 3'd3,
    WRLO  = 3'd4,
    WRHI  = 3'd5,
    DONE  = 3'd6
  } state_e;

  typedef logic [3:0] idx_t;

  typedef struct packed {
    idx_t ra;
    idx_t rb;
    idx_t rc;
  } req_t;

  function automatic logic is_muldiv(input logic [OPW-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_step_sequencer_onehot_dec4.sv
// 4-bit register index to NREGS-wide one-hot enable; bits above 15 are never
// reachable from a 4-bit index and stay 0.
module onehot_dec4 #(
  parameter int NREGS = 16
) (
  input  logic             en,
  input  logic [3:0]       idx,
  output logic [NREGS-1:0] onehot
);

  for (genvar i = 0; i < NREGS; i++) begin : g_bit
    if (i < 16) begin : g_live
      assign onehot[i] = en && (idx == 4'(i));
    end else begin : g_dead
      assign onehot[i] = 1'b0;
    end
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// Control-step sequencer for Ra <= Rb op Rc, driving DataPath transfer enables.
// Define HILO_WRITE_EN to route mul/div results into LO/HI instead of Ra.
module alu_step_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [3:0]       rc,
  output logic             busy,
  output logic             done,
  output logic [NREGS-1:0] reg_out,
  output logic [NREGS-1:0] reg_in,
  output logic             ry_in,
  output logic             ry_out,
  output logic             rz_in,
  output logic             rzlo_out,
  output logic             rzhi_out,
  output logic             lo_in,
  output logic             hi_in,
  output logic [OPW-1:0]   alu_ops
);

  import alu_seq_pkg::*;

  state_e         state_q, state_d;
  req_t           req_q, req_d;
  logic [OPW-1:0] op_q, op_d;

  logic out_en, in_en;
  idx_t out_idx, in_idx;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      req_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      op_q    <= op_d;
    end
  end

  // Fields are captured only on an accepted start, so input wiggle while busy is inert.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          req_d   = '{ra: ra, rb: rb, rc: rc};
          op_d    = op;
          state_d = LOADY;
        end
      end
      LOADY: state_d = EXEC;
      EXEC: begin
`ifdef HILO_WRITE_EN
        state_d = is_muldiv(op_q) ? WRLO : WRZ;
`else
        state_d = WRZ;
`endif
      end
      WRZ:  state_d = DONE;
`ifdef HILO_WRITE_EN
      WRLO: state_d = WRHI;
      WRHI: state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = 1'b0;
    ry_in    = 1'b0;
    ry_out   = 1'b0;
    rz_in    = 1'b0;
    rzlo_out = 1'b0;
    rzhi_out = 1'b0;
    lo_in    = 1'b0;
    hi_in    = 1'b0;
    out_en   = 1'b0;
    out_idx  = req_q.rb;
    in_en    = 1'b0;
    in_idx   = req_q.ra;
    alu_ops  = busy ? op_q : '0;
    case (state_q)
      LOADY: begin
        out_en  = 1'b1;
        out_idx = req_q.rb;
        ry_in   = 1'b1;
      end
      EXEC: begin
        out_en  = 1'b1;
        out_idx = req_q.rc;
        ry_out  = 1'b1;
        rz_in   = 1'b1;
      end
      WRZ: begin
        rzlo_out = 1'b1;
        in_en    = 1'b1;
        in_idx   = req_q.ra;
      end
`ifdef HILO_WRITE_EN
      WRLO: begin
        rzlo_out = 1'b1;
        lo_in    = 1'b1;
      end
      WRHI: begin
        rzhi_out = 1'b1;
        hi_in    = 1'b1;
      end
`endif
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  onehot_dec4 #(.NREGS(NREGS)) u_out_dec (
    .en     (out_en),
    .idx    (out_idx),
    .onehot (reg_out)
  );

  onehot_dec4 #(.NREGS(NREGS)) u_in_dec (
    .en     (in_en),
    .idx    (in_idx),
    .onehot (reg_in)
  );

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Randomized self-checking bench for alu_step_sequencer; expected per-cycle
// enables come from a step-list model built from the instruction semantics.
module tb_alu_step_sequencer;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
`ifdef HILO_WRITE_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [15:0] reg_out;
    logic [15:0] reg_in;
    logic        ry_in;
    logic        ry_out;
    logic        rz_in;
    logic        rzlo_out;
    logic        rzhi_out;
    logic        lo_in;
    logic        hi_in;
    logic [4:0]  alu_ops;
  } obs_t;

  logic        clock = 1'b0;
  logic        clear, start;
  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic        busy, done, ry_in, ry_out, rz_in, rzlo_out, rzhi_out, lo_in, hi_in;
  logic [15:0] reg_out, reg_in;
  logic [4:0]  alu_ops;

  int vectors = 0;
  int miscompares = 0;

  alu_step_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .busy(busy), .done(done), .reg_out(reg_out), .reg_in(reg_in),
    .ry_in(ry_in), .ry_out(ry_out), .rz_in(rz_in), .rzlo_out(rzlo_out),
    .rzhi_out(rzhi_out), .lo_in(lo_in), .hi_in(hi_in), .alu_ops(alu_ops)
  );

  always #5 clock = ~clock;

  function automatic obs_t sample();
    obs_t o;
    o = '{busy, done, reg_out, reg_in, ry_in, ry_out, rz_in, rzlo_out,
          rzhi_out, lo_in, hi_in, alu_ops};
    return o;
  endfunction

  // Step list for Ra <= Rb op Rc: every cycle after the accepted start, ending in IDLE.
  function automatic void build_model(input logic [4:0] o, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c,
                                      output obs_t q[$]);
    obs_t base, e;
    bit   hilo_path;
    hilo_path = HILO && (o == OP_MUL || o == OP_DIV);
    q = {};
    base = '0;
    base.busy = 1'b1;
    base.alu_ops = o;
    e = base; e.reg_out = 16'(1) << b; e.ry_in = 1'b1; q.push_back(e);
    e = base; e.reg_out = 16'(1) << c; e.ry_out = 1'b1; e.rz_in = 1'b1; q.push_back(e);
    if (hilo_path) begin
      e = base; e.rzlo_out = 1'b1; e.lo_in = 1'b1; q.push_back(e);
      e = base; e.rzhi_out = 1'b1; e.hi_in = 1'b1; q.push_back(e);
    end else begin
      e = base; e.rzlo_out = 1'b1; e.reg_in = 16'(1) << a; q.push_back(e);
    end
    e = base; e.done = 1'b1; q.push_back(e);
    q.push_back(obs_t'(0));
  endfunction

  // Call at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input string name, input logic [4:0] o, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c,
                         input bit poke_exec, input bit start_in_done);
    obs_t q[$];
    obs_t got;
    build_model(o, a, b, c, q);
    start = 1'b1; op = o; ra = a; rb = b; rc = c;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clock);
      got = sample();
      vectors++;
      if (got !== q[i]) begin
        miscompares++;
        $display("FAIL %s step %0d: got %h expected %h", name, i, got, q[i]);
      end
      start = 1'b0;
      op = 5'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      if (poke_exec && i == 1) start = 1'b1;
      if (start_in_done && q[i].done) start = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    clear = 1'b1; start = 1'b1; op = OP_ADD; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i == 2) begin clear = 1'b0; start = 1'b0; end
      if (i == 0) continue;
      got = sample();
      vectors++;
      if (got !== obs_t'(0)) begin
        miscompares++;
        $display("FAIL reset cycle %0d: got %h expected %h", i, got, obs_t'(0));
      end
    end
    @(negedge clock);
    got = sample();
    vectors++;
    if (got !== obs_t'(0)) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", got, obs_t'(0));
    end
  endtask

  task automatic test_and();
    run_txn("and_r1_r3_r2", OP_AND, 4'd1, 4'd3, 4'd2, 1'b0, 1'b0);
  endtask

  task automatic test_muldiv();
    run_txn("mul_r5_r3_r2", OP_MUL, 4'd5, 4'd3, 4'd2, 1'b0, 1'b0);
    run_txn("div_r0_r15_r9", OP_DIV, 4'd0, 4'd15, 4'd9, 1'b0, 1'b0);
  endtask

  task automatic test_aliasing();
    run_txn("alias_r7", OP_ADD, 4'd7, 4'd7, 4'd7, 1'b0, 1'b0);
    run_txn("alias_r15_mul", OP_MUL, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_txn("poke_exec", OP_ADD, 4'd4, 4'd9, 4'd11, 1'b1, 1'b0);
    run_txn("poke_exec_mul", OP_MUL, 4'd2, 4'd6, 4'd8, 1'b1, 1'b0);
  endtask

  // start raised during DONE must not be taken; IDLE follows and the bench step confirms it.
  task automatic test_start_in_done();
    run_txn("start_in_done", OP_AND, 4'd12, 4'd0, 4'd1, 1'b0, 1'b1);
  endtask

  task automatic test_clear_in_exec();
    obs_t got;
    start = 1'b1; op = OP_MUL; ra = 4'd3; rb = 4'd10; rc = 4'd5;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      clear = 1'b0;
      got = sample();
      vectors++;
      if (got !== obs_t'(0)) begin
        miscompares++;
        $display("FAIL clear_in_exec cycle %0d: got %h expected %h", i, got, obs_t'(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] o;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0: o = OP_ADD;
        1: o = OP_AND;
        2: o = OP_MUL;
        3: o = OP_DIV;
        default: o = 5'($urandom);
      endcase
      run_txn("back_to_back", o, 4'($urandom), 4'($urandom), 4'($urandom),
              1'($urandom), 1'b0);
    end
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
    @(negedge clock);
    test_reset();
    test_and();
    test_muldiv();
    test_aliasing();
    test_start_while_busy();
    test_start_in_done();
    test_clear_in_exec();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_step_sequencer.md
Name: alu_step_sequencer

Overview:
- Control-step generator that sits directly upstream of DataPath and drives its register-transfer enables and ALU op code.
- Replaces hand-written T-state stimulus with a sequencer for register-register ALU instructions: Ra <= Rb op Rc.
- Mul/div results can optionally be routed to LO/HI.
- Outputs drive DataPath's Rx_out/Rx_in, RYin/RYout, RZin, RZLOout/RZHIout, HIin/LOin and ops directly.

Parameters:
- NREGS, 16, number of general registers; width of the one-hot out/in vectors.
- OPW, 5, ALU op code width; matches DataPath ops.

Ports:
- clock  in  1  system clock, all state changes on posedge.
- clear  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  OPW  ALU op code, latched on accepted start.
- ra  in  4  destination register index, latched on start.
- rb  in  4  first source index, latched on start.
- rc  in  4  second source index, latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- reg_out  out  NREGS  one-hot Rx_out enables.
- reg_in  out  NREGS  one-hot Rx_in enables.
- ry_in  out  1  Y register load enable.
- ry_out  out  1  Y register drive enable.
- rz_in  out  1  Z register load enable.
- rzlo_out  out  1  Z low-word drive enable.
- rzhi_out  out  1  Z high-word drive enable.
- lo_in  out  1  LO register load enable.
- hi_in  out  1  HI register load enable.
- alu_ops  out  OPW  op code to the ALU.

Behaviour:
- Clock and reset: one clock (clock); reset clear is synchronous and active-high. Asserting clear at a posedge forces IDLE and clears all latched fields.
- Reset values: all outputs 0. This holds one cycle after clear, including when clear arrives mid-operation; no partial enables leak.
- Output timing: Moore outputs, decoded from registered state plus latched fields. They change only just after posedge.
- IDLE: all enables 0. If start=1 at a posedge, latch op/ra/rb/rc and go to LOADY.
- LOADY: reg_out[rb]=1, ry_in=1. Next state EXEC.
- EXEC: reg_out[rc]=1, ry_out=1, rz_in=1. Next state WRZ, or WRLO when the feature is enabled and op is OP_MUL or OP_DIV.
- WRZ: rzlo_out=1, reg_in[ra]=1. Next state DONE.
- WRLO: rzlo_out=1, lo_in=1. Next state WRHI.
- WRHI: rzhi_out=1, hi_in=1. Next state DONE.
- DONE: done=1, no enables. Next state IDLE; a new start is accepted one cycle later, in IDLE.
- alu_ops: equals the latched op whenever busy=1, otherwise 0.
- Latency: start to done is 4 cycles normal, 5 cycles mul/div.
- Start while busy: ignored, not queued.
- Input stability: op/ra/rb/rc changes during busy have no effect.
- Bus exclusivity: at most one bus driver asserted per cycle, except EXEC where reg_out[rc] and ry_out drive the separate bus and Y paths.
- Register aliasing: ra==rb==rc is legal and follows the same sequence.
- One-hot rule: reg_out and reg_in each have at most one bit set; NREGS must be >= 16 for the 4-bit indices.

Optional Feature:
- Macro: HILO_WRITE_EN.
- Defined: OP_MUL and OP_DIV take the WRLO/WRHI path; reg_in stays 0 for those ops; total 6 states visited.
- Undefined: WRLO/WRHI are not built; mul/div follow WRZ (Z low word to Ra); lo_in and hi_in are tied 0.

Decomposition:
- Shared package alu_seq_pkg:
  - State enum: IDLE, LOADY, EXEC, WRZ, WRLO, WRHI, DONE.
  - OPW constant.
  - Op codes OP_ADD=5'b00011, OP_AND=5'b00101, OP_MUL=5'b01110, OP_DIV=5'b01111.
- Sub-module onehot_dec4: 4-bit index plus enable in, NREGS one-hot out. Instantiated twice, for reg_out and reg_in.

Test Plan:
- Reset: clear=1 for 2 cycles with start=1 -> all outputs 0, busy=0; start is not accepted until clear falls.
- AND R1 <= R3 & R2: start, op=00101, ra=1, rb=3, rc=2 ->
  - cycle+1: reg_out=0x0008, ry_in;
  - cycle+2: reg_out=0x0004, ry_out, rz_in, alu_ops=00101;
  - cycle+3: rzlo_out, reg_in=0x0002;
  - cycle+4: done=1;
  - with DataPath and R3=13, R2=6: R1=4.
- MUL with HILO_WRITE_EN: op=01110, rb=3, rc=2 -> after EXEC, WRLO (rzlo_out+lo_in) then WRHI (rzhi_out+hi_in); reg_in stays 0; done at cycle+5; with DataPath, LO=78, HI=0.
- MUL without the macro -> same sequence as AND; reg_in[ra] asserted; done at cycle+4; lo_in/hi_in never 1.
- Start pulsed during EXEC with different fields -> ignored; the sequence completes with the original fields; back-to-back start in the cycle after done is accepted.
- clear asserted in EXEC -> next cycle IDLE, all enables 0, done never pulses.
